mac_stream: RTL and testbench
=============================

Name: mac_stream

Overview:
Parametrised streaming multiply-accumulate unit. It is the successor to the fixed 8-bit, 4-deep MAC.
- Accepts operand pairs over a valid/ready handshake.
- Accumulates COUNT products per group, in signed or unsigned mode.
- Emits one registered result per group over a valid/ready output with backpressure.
- Sits between the operand front end and the result/IO stage.

Parameters:
IN_W, 8, operand width in bits (>=2)
COUNT, 4, products accumulated per group (>=2)
ACC_W, 2*IN_W+$clog2(COUNT), internal accumulator width; derived, do not override below this value
OUT_W, ACC_W, result width presented on out_data (2 <= OUT_W <= ACC_W)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
clear  input  1  synchronous abort of the partial group in progress
mode_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on first beat of a group
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operand pair
in_a  input  IN_W  operand A
in_b  input  IN_W  operand B
out_valid  output  1  out_data holds a completed group result
out_ready  input  1  downstream accepts result
out_data  output  OUT_W  group result
busy  output  1  partial group in progress (cnt != 0)

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high.
- Reset values: acc=0, cnt=0, mode_q=0, out_valid=0, out_data=0, busy=0.
- rst overrides every other input, including mid-group and with a result pending. A pending result is discarded.
- in_ready = !out_valid || out_ready (combinational). A full output register that is not being drained stalls input.
- Beat: an input beat occurs when in_valid && in_ready.
- Product: in_a*in_b, exactly 2*IN_W bits, then sign- or zero-extended to ACC_W.
  - Signed mode uses mode_signed on the first beat (cnt==0); later beats use mode_q.
  - mode_q is latched on the first beat. mode_signed changes mid-group are ignored.
- Beat with cnt < COUNT-1: acc <= acc + product; cnt <= cnt+1.
- Beat with cnt == COUNT-1:
  - out_data <= fmt(acc + product); out_valid <= 1.
  - acc <= 0; cnt <= 0.
- Latency: the result is visible the cycle after the final beat is accepted.
- out_valid clears on out_valid && out_ready, unless a new result loads in the same cycle. In that case out_valid stays 1 and out_data updates, giving back-to-back throughput of one result per COUNT beats with no bubbles.
- out_data holds stable while out_valid && !out_ready.
- ACC_W arithmetic wraps modulo 2^ACC_W. ACC_W is sized so that a full group cannot overflow in either mode.
- fmt(): takes the low OUT_W bits of the ACC_W sum (truncation), unless MAC_SAT_EN is defined.
- clear (when rst=0): acc <= 0; cnt <= 0; any beat presented in that cycle is dropped.
  - in_ready is unaffected by clear.
  - A pending out_valid/out_data is preserved and still drains normally.
- busy = (cnt != 0).
- No further states beyond cnt (0..COUNT-1) and the output-full flag.

Optional Feature:
Macro MAC_SAT_EN.
- Defined: fmt() saturates the ACC_W sum to the OUT_W range of the group's mode.
  - Unsigned: values > 2^OUT_W-1 give 2^OUT_W-1.
  - Signed: values are clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - When OUT_W == ACC_W, saturation is a no-op.
- Undefined: plain truncation to the low OUT_W bits, with no saturation logic synthesised.

Test Plan:
- Defaults, unsigned: 4 beats of 255*255, out_ready=1 → out_valid pulses one cycle after 4th beat; out_data=0x3F804 (260100); busy 1 after beats 1–3, 0 after beat 4.
- Signed: 4 beats of (-128)*(-128) → 65536 (0x10000). Next group 4 beats of (-128)*127 → -65024 (ACC_W=18: 0x30200). Toggling mode_signed on beats 2–4 does not change either result.
- Backpressure:
  - Complete one group, hold out_ready=0 → in_ready=0; out_data stable for 10 cycles; in_valid beats ignored.
  - Raise out_ready → in_ready=1 in the same cycle.
  - Back-to-back groups with out_ready=1 → one result every 4 beats, no idle cycle.
- Clear/reset mid-group:
  - 2 beats of 10*10, then clear, then 4 beats of 1*1 → out_data=4.
  - With a result pending (out_ready=0), pulse clear → result retained.
  - Pulse rst → out_valid=0, out_data=0, busy=0 next cycle.
- MAC_SAT_EN with OUT_W=16, unsigned, 4×(255*255) → 0xFFFF. Same stimulus without the macro → 0xF804.
- MAC_SAT_EN with OUT_W=16, signed, 4×(-128*127) → 0x8000 (-32768). Without the macro → 0x0200.

Source files
------------

// File: rtl/mac_stream_if.sv
// mac_stream_if: operand/result stream bundle for mac_stream.
//   in_valid/in_ready/in_a/in_b    : operand pair channel (master -> slave)
//   out_valid/out_ready/out_data   : group result channel (slave -> master)
// master = operand source / result sink, slave = the MAC.
interface mac_stream_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2*IN_W+2
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_a;
  logic [IN_W-1:0]  in_b;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (output in_valid, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/mac_stream.sv
// mac_stream: streaming multiply-accumulate. Sums COUNT products per group
// (signed or unsigned, mode latched on the first beat) and emits one
// registered result per group with backpressure.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : abort partial group (pending result kept)
//   mode_signed  : 1 = two's-complement operands, sampled on first beat
//   s (slave)    : operand channel in / result channel out
//   busy         : partial group in progress
// Optional feature: define MAC_SAT_EN to saturate the result to OUT_W
// in the group's mode instead of truncating.
module mac_stream #(
  parameter int IN_W  = 8,
  parameter int COUNT = 4,
  parameter int ACC_W = 2*IN_W + $clog2(COUNT),
  parameter int OUT_W = ACC_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          mode_signed,
  mac_stream_if.slave   s,
  output logic          busy
);
  localparam int CNT_W = $clog2(COUNT);
  localparam int PW    = 2*IN_W;

  logic [ACC_W-1:0]     acc, prod_ext, sum;
  logic [CNT_W-1:0]     cnt;
  logic                 mode_q, sgn, beat, last;
  logic                 out_valid_q;
  logic [OUT_W-1:0]     out_data_q, res;
  logic signed [PW-1:0] a_x, b_x, prod;

  assign s.in_ready  = !out_valid_q || s.out_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign busy        = (cnt != '0);

  assign beat = s.in_valid && s.in_ready;
  assign last = (cnt == CNT_W'(COUNT-1));
  // first beat takes the live mode; the rest of the group uses the latched one
  assign sgn  = (cnt == '0) ? mode_signed : mode_q;

  // operands extended to the product width so the multiply is exact in
  // both modes and the low PW bits are the true product
  assign a_x      = {{(PW-IN_W){sgn & s.in_a[IN_W-1]}}, s.in_a};
  assign b_x      = {{(PW-IN_W){sgn & s.in_b[IN_W-1]}}, s.in_b};
  assign prod     = a_x * b_x;
  assign prod_ext = {{(ACC_W-PW){sgn & prod[PW-1]}}, prod};
  assign sum      = acc + prod_ext;

`ifdef MAC_SAT_EN
  // in range when everything above the result field is zero (unsigned) or
  // a pure sign extension (signed); with OUT_W == ACC_W both tests always pass
  logic [ACC_W-1:0]        hi_u;
  logic signed [ACC_W-1:0] hi_s;
  assign hi_u = sum >> OUT_W;
  assign hi_s = $signed(sum) >>> (OUT_W-1);

  always_comb begin
    res = sum[OUT_W-1:0];
    if (sgn) begin
      if (!(hi_s == '0 || hi_s == '1))
        res = sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else if (hi_u != '0) begin
      res = '1;
    end
  end
`else
  assign res = sum[OUT_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (out_valid_q && s.out_ready) out_valid_q <= 1'b0;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (beat) begin
        if (cnt == '0) mode_q <= mode_signed;
        if (last) begin
          // a load here overrides the drain above, so back-to-back results keep out_valid high
          out_data_q  <= res;
          out_valid_q <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_stream.sv
// tb_mac_stream: directed + short random stimulus for mac_stream with a
// reference scoreboard. Two instances share stimulus: OUT_W=18 (full
// width) and OUT_W=16 (truncated, or saturated under MAC_SAT_EN).
module tb_mac_stream;
  logic clk = 1'b0;
  logic rst, clear, mode_signed;
  logic busy18, busy16;
  int   ncmp = 0;
  int   nerr = 0;

  mac_stream_if #(.IN_W(8), .OUT_W(18)) i18();
  mac_stream_if #(.IN_W(8), .OUT_W(16)) i16();

  assign i16.in_valid  = i18.in_valid;
  assign i16.in_a      = i18.in_a;
  assign i16.in_b      = i18.in_b;
  assign i16.out_ready = i18.out_ready;

  mac_stream #(.IN_W(8), .COUNT(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .mode_signed(mode_signed),
    .s(i18), .busy(busy18));

  mac_stream #(.IN_W(8), .COUNT(4), .OUT_W(16)) dut16 (
    .clk(clk), .rst(rst), .clear(clear), .mode_signed(mode_signed),
    .s(i16), .busy(busy16));

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [17:0] q18[$];
  logic [15:0] q16[$];
  longint      m_sum = 0;
  int          m_cnt = 0;
  bit          m_sg  = 0;

  function automatic logic [15:0] fmt16(longint v, bit sg);
`ifdef MAC_SAT_EN
    if (sg) begin
      if (v > 32767)  return 16'h7FFF;
      if (v < -32768) return 16'h8000;
    end else if (v > 65535) begin
      return 16'hFFFF;
    end
`endif
    return sg ? v[15:0] : v[15:0];
  endfunction

  // sampled on the falling edge: handshake/beat values are those the next
  // rising edge will act on
  always @(negedge clk) begin
    logic [17:0] e18;
    logic [15:0] e16;
    longint      p;
    bit          sg;
    if (i18.out_valid === 1'b1 && i18.out_ready === 1'b1) begin
      ncmp++;
      if (q18.size() == 0) begin
        nerr++;
        $error("FAIL sb18_extra: got 0x%0h want none", i18.out_data);
      end else begin
        e18 = q18.pop_front();
        assert (i18.out_data === e18) else begin
          nerr++;
          $error("FAIL sb18: got 0x%0h want 0x%0h", i18.out_data, e18);
        end
      end
    end
    if (i16.out_valid === 1'b1 && i16.out_ready === 1'b1) begin
      ncmp++;
      if (q16.size() == 0) begin
        nerr++;
        $error("FAIL sb16_extra: got 0x%0h want none", i16.out_data);
      end else begin
        e16 = q16.pop_front();
        assert (i16.out_data === e16) else begin
          nerr++;
          $error("FAIL sb16: got 0x%0h want 0x%0h", i16.out_data, e16);
        end
      end
    end
    if (rst === 1'b1) begin
      m_sum = 0; m_cnt = 0;
      q18.delete(); q16.delete();
    end else if (clear === 1'b1) begin
      m_sum = 0; m_cnt = 0;
    end else if (i18.in_valid === 1'b1 && i18.in_ready === 1'b1) begin
      sg = (m_cnt == 0) ? mode_signed : m_sg;
      if (m_cnt == 0) m_sg = mode_signed;
      p = sg ? longint'($signed(i18.in_a)) * longint'($signed(i18.in_b))
             : longint'(i18.in_a) * longint'(i18.in_b);
      m_sum += p;
      if (m_cnt == 3) begin
        q18.push_back(m_sum[17:0]);
        q16.push_back(fmt16(m_sum, sg));
        m_sum = 0; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic ms);
    i18.in_valid = 1'b1;
    i18.in_a     = a;
    i18.in_b     = b;
    mode_signed  = ms;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; clear = 1'b0; mode_signed = 1'b0;
    i18.in_valid = 1'b0; i18.in_a = '0; i18.in_b = '0; i18.out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", 32'(i18.out_valid), 32'd0);
    chk("rst_out_data",  32'(i18.out_data),  32'd0);
    chk("rst_out_data16", 32'(i16.out_data), 32'd0);
    chk("rst_busy",      32'(busy18),        32'd0);
    chk("rst_in_ready",  32'(i18.in_ready),  32'd1);
    rst = 1'b0;
    tick();

    // unsigned 4 x 255*255
    for (int i = 0; i < 4; i++) begin
      drive(8'd255, 8'd255, 1'b0);
      chk("u_busy", 32'(busy18), (i < 3) ? 32'd1 : 32'd0);
    end
    i18.in_valid = 1'b0;
    chk("u_valid", 32'(i18.out_valid), 32'd1);
    chk("u_data",  32'(i18.out_data),  32'h3F804);
`ifdef MAC_SAT_EN
    chk("u_data16", 32'(i16.out_data), 32'hFFFF);
`else
    chk("u_data16", 32'(i16.out_data), 32'hF804);
`endif
    tick();
    chk("u_pulse_end", 32'(i18.out_valid), 32'd0);

    // signed, mode toggling on beats 2..4 must be ignored
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++)
        drive(8'h80, (g == 0) ? 8'h80 : 8'h7F, (i % 2) == 0);
      if (g == 0) begin
        chk("s_data_a", 32'(i18.out_data), 32'h10000);
`ifdef MAC_SAT_EN
        chk("s_data16_a", 32'(i16.out_data), 32'h7FFF);
`else
        chk("s_data16_a", 32'(i16.out_data), 32'h0000);
`endif
      end else begin
        chk("s_data_b", 32'(i18.out_data), 32'h30200);
`ifdef MAC_SAT_EN
        chk("s_data16_b", 32'(i16.out_data), 32'h8000);
`else
        chk("s_data16_b", 32'(i16.out_data), 32'h0200);
`endif
      end
    end
    i18.in_valid = 1'b0;
    tick();

    // back-to-back groups, no idle cycles
    for (int k = 0; k < 12; k++) begin
      chk("b2b_in_ready", 32'(i18.in_ready), 32'd1);
      drive(8'(k/4 + 1), 8'd2, 1'b0);
      if (k % 4 == 3) begin
        chk("b2b_valid", 32'(i18.out_valid), 32'd1);
        chk("b2b_data",  32'(i18.out_data),  32'(8*(k/4 + 1)));
      end
    end
    i18.in_valid = 1'b0;
    tick();

    // backpressure: held result stalls input
    i18.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(8'd3, 8'd5, 1'b0);
    i18.in_a = 8'd9; i18.in_b = 8'd9;
    chk("bp_valid", 32'(i18.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_data",     32'(i18.out_data), 32'd60);
      chk("bp_in_ready", 32'(i18.in_ready), 32'd0);
    end
    chk("bp_busy", 32'(busy18), 32'd0);
    i18.in_valid  = 1'b0;
    i18.out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(i18.in_ready), 32'd1);
    tick();
    chk("bp_drained", 32'(i18.out_valid), 32'd0);

    // clear mid-group, beat presented with clear is dropped
    drive(8'd10, 8'd10, 1'b0);
    drive(8'd10, 8'd10, 1'b0);
    chk("clr_busy_pre", 32'(busy18), 32'd1);
    i18.in_a = 8'd7; i18.in_b = 8'd7; clear = 1'b1;
    tick();
    clear = 1'b0;
    i18.in_valid = 1'b0;
    chk("clr_busy_post", 32'(busy18), 32'd0);
    for (int i = 0; i < 4; i++) drive(8'd1, 8'd1, 1'b0);
    i18.in_valid = 1'b0;
    chk("clr_data", 32'(i18.out_data), 32'd4);
    tick();

    // clear with a result pending keeps the result
    i18.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(8'd2, 8'd3, 1'b0);
    i18.in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    chk("clrp_valid", 32'(i18.out_valid), 32'd1);
    chk("clrp_data",  32'(i18.out_data),  32'd24);
    i18.out_ready = 1'b1;
    tick();
    chk("clrp_drained", 32'(i18.out_valid), 32'd0);

    // reset discards a pending result
    i18.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(8'd1, 8'd1, 1'b0);
    i18.in_valid = 1'b0;
    chk("rstp_valid_pre", 32'(i18.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstp_valid", 32'(i18.out_valid), 32'd0);
    chk("rstp_data",  32'(i18.out_data),  32'd0);
    chk("rstp_busy",  32'(busy18),        32'd0);
    i18.out_ready = 1'b1;

    // reset mid-group, then a fresh group starts from zero
    drive(8'd5, 8'd5, 1'b0);
    drive(8'd5, 8'd5, 1'b0);
    i18.in_valid = 1'b0;
    chk("rstm_busy_pre", 32'(busy18), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstm_busy", 32'(busy18), 32'd0);
    for (int i = 0; i < 4; i++) drive(8'd1, 8'd2, 1'b0);
    i18.in_valid = 1'b0;
    chk("rstm_data", 32'(i18.out_data), 32'd8);
    tick();

    // random traffic, checked by the scoreboard
    for (int c = 0; c < 200; c++) begin
      i18.in_valid  = ($urandom_range(0, 3) != 0);
      i18.in_a      = 8'($urandom);
      i18.in_b      = 8'($urandom);
      mode_signed   = 1'($urandom_range(0, 1));
      i18.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    i18.in_valid  = 1'b0;
    i18.out_ready = 1'b1;
    repeat (4) tick();
    chk("sb18_empty", 32'(q18.size()), 32'd0);
    chk("sb16_empty", 32'(q16.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
